muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It executes the MIPS R-type HI/LO group (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO) selected by the instruction funct field. It sits beside the ALU in the execute stage. It exposes a start/busy/done handshake and a stall indication so the datapath can hold MFHI/MFLO until a pending result lands.

## Interface
- WIDTH, default 32: operand and HI/LO width, at least 2.
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- funct  in  6  R-type funct code selecting the operation.
- a  in  WIDTH  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- b  in  WIDTH  rt operand: divisor or multiplier.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse; HI/LO updated by an operation.
- illegal  out  1  one-cycle pulse; start with an unsupported funct.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd_data  out  WIDTH  hi if funct=MFHI, lo if funct=MFLO, else 0 (combinational).
- mf_stall  out  1  busy & (funct is MFHI or MFLO), combinational.

## Operation
- Funct codes:
  - 010000 MFHI
  - 010001 MTHI
  - 010010 MFLO
  - 010011 MTLO
  - 011000 MULT
  - 011001 MULTU
  - 011010 DIV
  - 011011 DIVU
  - Any other code is illegal.
- States:
  - IDLE: accepts start.
  - RUN: WIDTH iterations, one per cycle.
  - FIX: sign correction and HI/LO write.
- IDLE with start=1:
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes and sign flags; clear counter; go to RUN.
  - MTHI/MTLO: hi<=a or lo<=a at that edge; done=1 next cycle; stay IDLE.
  - MFHI/MFLO: no state change, no pulse.
  - Other funct: illegal=1 next cycle; no state change.
- Signed ops (MULT/DIV) operate on magnitudes; unsigned ops zero-extend.
- Multiply: shift-add, one multiplier bit per RUN cycle, 2*WIDTH-bit accumulator. In FIX, negate the 2*WIDTH product if sign(a)^sign(b) on MULT. hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide: restoring, one quotient bit per RUN cycle.
  - In FIX on DIV: negate quotient if sign(a)^sign(b); remainder takes sign(a).
  - lo = quotient, hi = remainder.
- Divide by zero (b=0, DIV or DIVU): lo = all ones, hi = a. No trap. Full latency still applies.
- Signed overflow (DIV of most-negative by −1): lo = most-negative, hi = 0.
- RUN → FIX when the counter reaches WIDTH−1 iterations done. FIX → IDLE unconditionally.
- hi/lo keep their previous values throughout RUN; they change only at the FIX edge.
- start while busy=1 is ignored entirely: no illegal pulse, operands not relatched.
- Counter width is $clog2(WIDTH+1).

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, busy=0, done=0, illegal=0, hi=0, lo=0, internal accumulators 0.
  - Reset mid-operation aborts it; HI/LO are cleared, not restored.
- Multiply/divide accepted at rising edge t0:
  - busy=1 from t0 through edge t0+WIDTH+1, i.e. WIDTH+1 cycles.
  - RUN iterations occur at edges t0+1 … t0+WIDTH.
  - FIX at edge t0+WIDTH+1 writes hi/lo, sets done=1 and busy=0 in the same cycle.
- A new start may be accepted at the edge after busy falls. Back-to-back operations give done every WIDTH+2 cycles.
- MTHI/MTLO: hi/lo updated at edge t0; done=1 during cycle t0..t0+1; busy stays 0.
- done and illegal are registered and high for exactly one cycle.
- rd_data and mf_stall are combinational from funct, busy, hi, lo. They show old HI/LO while busy.

## Test plan
- WIDTH=32, MULTU a=FFFFFFFF b=FFFFFFFF:
  - Required: hi=FFFFFFFE, lo=00000001.
  - busy high exactly 33 cycles; done pulses once, coincident with busy falling.
- MULT a=FFFFFFFD (−3) b=00000007:
  - Required: hi=FFFFFFFF, lo=FFFFFFEB (−21).
- DIV, then DIVU:
  - DIV a=FFFFFFF9 (−7) b=00000002: lo=FFFFFFFD, hi=FFFFFFFF.
  - DIVU a=00000007 b=0: lo=FFFFFFFF, hi=00000007, after the full 33-cycle latency.
- DIV overflow and start while busy:
  - DIV a=80000000 b=FFFFFFFF: lo=80000000, hi=00000000.
  - A second start with MULT during busy is ignored: no illegal pulse, result unchanged.
- MTHI and MF stall:
  - MTHI a=00001234 → hi=00001234 next cycle, done pulse, busy never set.
  - Then funct=MFHI → rd_data=00001234.
  - During a later DIV, funct=MFLO → mf_stall=1 until done.
- Illegal funct and reset mid-operation:
  - start with funct=100000 → illegal pulses for one cycle; hi/lo unchanged.
  - Separately, reset_n low 10 cycles into a DIV → busy=0, hi=lo=0 immediately.
  - After release, a MULTU 3×5 gives lo=0000000F, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Implements the MIPS HI/LO instruction group (MULT, MULTU, DIV, DIVU, MTHI,
// MTLO, MFHI, MFLO). Multiply is shift-add and divide is restoring, both one
// bit per cycle on operand magnitudes, with sign correction in a final FIX cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             mf_stall
);

  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend/quotient bits}.
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic                   is_div_q, is_div_d;
  logic                   neg_res_q, neg_res_d;
  logic                   neg_rem_q, neg_rem_d;
  logic                   div0_q, div0_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;
  logic                   illegal_q, illegal_d;

  // Operand magnitude and sign decode for the incoming request.
  logic                   signed_op;
  logic                   a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic                   req_div;

  // One iteration of each algorithm, plus the sign-corrected final results.
  logic [WIDTH-1:0]       mul_addend;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH+1:0]       div_diff;
  logic                   div_ok;
  logic [WIDTH-1:0]       div_rem;
  logic [2*WIDTH-1:0]     div_next;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix;
  logic [WIDTH-1:0]       rem_fix;

  // Decode operand signs and magnitudes for a new request.
  always_comb begin
    signed_op = ~funct[0];
    req_div   = funct[1];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // Single iteration datapath for shift-add multiply and restoring divide.
  always_comb begin
    mul_addend = acc_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ok     = ~div_diff[WIDTH+1];
    div_rem    = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next   = {div_rem, acc_q[WIDTH-2:0], div_ok};
  end

  // Sign correction applied in the FIX cycle.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    // Divide by zero yields all-ones quotient; the remainder path already
    // reconstructs the original dividend since every quotient bit sets.
    quo_fix  = div0_q ? '1 :
               (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the IDLE/RUN/FIX sequencer and HI/LO.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (funct)
            FnMult, FnMultu, FnDiv, FnDivu: begin
              state_d   = StRun;
              cnt_d     = '0;
              is_div_d  = req_div;
              acc_d     = {{WIDTH{1'b0}}, (req_div ? a_mag : b_mag)};
              opnd_d    = req_div ? b_mag : a_mag;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = req_div & (b == '0);
            end
            FnMthi: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            FnMtlo: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            FnMfhi, FnMflo: ;
            default: illegal_d = 1'b1;
          endcase
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs: handshake from registers, MF read path combinational.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = done_q;
    illegal  = illegal_q;
    hi       = hi_q;
    lo       = lo_q;
    rd_data  = (funct == FnMfhi) ? hi_q :
               (funct == FnMflo) ? lo_q : '0;
    mf_stall = busy & ((funct == FnMfhi) | (funct == FnMflo));
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random
// operations checked against an arithmetic reference of HI/LO.
module tb_muldiv_unit;

  localparam int W = 32;

  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         busy, done, illegal, mf_stall;
  logic [W-1:0] hi, lo, rd_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference architectural state.
  logic [W-1:0] m_hi, m_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .hi       (hi),
    .lo       (lo),
    .rd_data  (rd_data),
    .mf_stall (mf_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // HI/LO after an operation, from plain arithmetic.
  task automatic ref_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = {m_hi, m_lo};
    case (f)
      MULT:  p = sx * sy;
      MULTU: p = {32'b0, x} * {32'b0, y};
      DIV: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
      MTHI: p = {x, m_lo};
      MTLO: p = {m_hi, x};
      default: ;
    endcase
    {m_hi, m_lo} = p;
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [5:0] f, input logic [W-1:0] h,
                                          input logic [W-1:0] l);
    if (f == MFHI) return h;
    if (f == MFLO) return l;
    return '0;
  endfunction

  // Multi-cycle op: checks every cycle of busy, the done cycle and the one after.
  // hold_f is driven on funct while busy; inj >= 0 fires an ignored MULT start.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [5:0] hold_f, input int inj);
    logic [W-1:0] o_hi, o_lo, e_hi, e_lo;
    bit           in_busy;
    @(negedge clk);
    funct = f; a = x; b = y; start = 1'b1;
    o_hi = m_hi; o_lo = m_lo;
    ref_op(f, x, y);
    for (int i = 0; i <= W + 1; i++) begin
      @(negedge clk);
      start = (i == inj);
      funct = (i == inj) ? MULT : hold_f;
      a = $urandom; b = $urandom;
      #1;
      in_busy = (i <= W);
      e_hi = in_busy ? o_hi : m_hi;
      e_lo = in_busy ? o_lo : m_lo;
      chk("busy",     busy,     in_busy);
      chk("done",     done,     !in_busy);
      chk("illegal",  illegal,  1'b0);
      chk("hi",       hi,       e_hi);
      chk("lo",       lo,       e_lo);
      chk("mf_stall", mf_stall, in_busy && (funct == MFHI || funct == MFLO));
      chk("rd_data",  rd_data,  exp_rd(funct, e_hi, e_lo));
    end
    @(negedge clk);
    start = 1'b0; funct = 6'b0;
    #1;
    chk("done_pulse", done, 1'b0);
    chk("idle_busy",  busy, 1'b0);
  endtask

  task automatic mt_op(input logic [5:0] f, input logic [W-1:0] x);
    @(negedge clk);
    funct = f; a = x; start = 1'b1;
    ref_op(f, x, '0);
    @(negedge clk);
    start = 1'b0;
    funct = (f == MTHI) ? MFHI : MFLO;
    #1;
    chk("mt_done",     done,     1'b1);
    chk("mt_busy",     busy,     1'b0);
    chk("mt_hi",       hi,       m_hi);
    chk("mt_lo",       lo,       m_lo);
    chk("mf_rd",       rd_data,  (f == MTHI) ? m_hi : m_lo);
    chk("mf_nostall",  mf_stall, 1'b0);
    @(negedge clk);
    #1;
    chk("mt_done_end", done, 1'b0);
    chk("mt_busy_end", busy, 1'b0);
  endtask

  initial begin
    logic [5:0]   ops[6];
    logic [5:0]   holds[4];
    logic [5:0]   f;
    logic [W-1:0] x, y;
    int           inj;
    ops   = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO};
    holds = '{MFHI, MFLO, 6'b0, MTHI};

    // Reset state.
    reset_n = 1'b0; start = 1'b0; funct = 6'b0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    #2;
    chk("rst_busy",    busy,    1'b0);
    chk("rst_done",    done,    1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_hi",      hi,      '0);
    chk("rst_lo",      lo,      '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // MULTU full-range.
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'b0, -1);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // MULT -3 * 7.
    run_op(MULT, 32'hFFFF_FFFD, 32'h0000_0007, 6'b0, -1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    // DIV -7 / 2, then DIVU by zero.
    run_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 6'b0, -1);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    run_op(DIVU, 32'h0000_0007, 32'h0, 6'b0, -1);
    chk("divu0_hi", hi, 32'h0000_0007);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);

    // Signed overflow with an ignored MULT start mid-operation.
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'b0, 5);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_lo", lo, 32'h8000_0000);

    // MTHI then MFHI, then MFLO stall during a DIV.
    mt_op(MTHI, 32'h0000_1234);
    chk("mthi_hi", hi, 32'h0000_1234);
    run_op(DIV, 32'd100, 32'd7, MFLO, -1);

    // Illegal funct.
    @(negedge clk);
    funct = 6'b100000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("ill_pulse", illegal, 1'b1);
    chk("ill_busy",  busy,    1'b0);
    chk("ill_done",  done,    1'b0);
    chk("ill_hi",    hi,      m_hi);
    chk("ill_lo",    lo,      m_lo);
    @(negedge clk);
    #1;
    chk("ill_end",   illegal, 1'b0);

    // Reset 10 cycles into a DIV.
    @(negedge clk);
    funct = DIV; a = 32'h1234_5678; b = 32'h0000_0013; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi",   hi,   '0);
    chk("abort_lo",   lo,   '0);
    chk("abort_done", done, 1'b0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_op(MULTU, 32'd3, 32'd5, 6'b0, -1);
    chk("post_hi", hi, 32'h0);
    chk("post_lo", lo, 32'h0000_000F);

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      f = ops[$urandom_range(0, 5)];
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = '0;
        1:       y = W'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      if (f == MTHI || f == MTLO) begin
        mt_op(f, x);
      end else begin
        inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W)) : -1;
        run_op(f, x, y, holds[$urandom_range(0, 3)], inj);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
